// File: rtl/dcache_responder.sv
// Direct-mapped, blocking, write-through / no-write-allocate data cache responder.
// Optional hit/miss counters are enabled by defining DCACHE_PERF_CNT_EN.
module dcache_responder #(
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ok,
  output logic [31:0] rdata,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_rdy,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_req,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_strb,
  input  logic        mem_wr_rdy,
  input  logic        mem_wr_done
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINE_LSB = OFFSET_W + 2;
  localparam int LINE_W   = 32 - LINE_LSB;
  localparam int TAG_W    = LINE_W - INDEX_W;
  localparam int SETS     = 1 << INDEX_W;
  localparam int WORDS    = 1 << OFFSET_W;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t                state_reg;
  logic [OFFSET_W-1:0]   cnt_reg;
  logic [SETS-1:0]       valid_reg;
  logic [LINE_W-1:0]     fill_line_reg;
  logic                  refilled_reg;
  logic [TAG_W-1:0]      tag_mem  [SETS];
  logic [31:0]           data_mem [SETS][WORDS];

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_idx;
  logic [OFFSET_W-1:0]   req_off;
  logic [INDEX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic                  load_hit;
  logic                  store_done;
  logic                  last_beat;
  logic [31:0]           cur_word;
  logic [31:0]           merged_word;
  logic                  unused_addr_bits;

  assign req_tag  = req_addr[31 -: TAG_W];
  assign req_idx  = req_addr[LINE_LSB +: INDEX_W];
  assign req_off  = req_addr[2 +: OFFSET_W];
  assign fill_idx = fill_line_reg[INDEX_W-1:0];
  assign fill_tag = fill_line_reg[LINE_W-1 -: TAG_W];
  assign unused_addr_bits = &{1'b0, req_addr[1:0]};

  assign hit        = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  assign load_hit   = (state_reg == IDLE) && req_valid && !req_we && hit;
  assign store_done = (state_reg == WR_RESP) && mem_wr_done;
  assign last_beat  = (state_reg == RD_DATA) && mem_rd_valid &&
                      (cnt_reg == OFFSET_W'(WORDS - 1));
  assign cur_word   = data_mem[req_idx][req_off];

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_word[8*gi +: 8] = req_wstrb[gi] ? req_wdata[8*gi +: 8] : cur_word[8*gi +: 8];
  end

  assign ok          = load_hit || store_done;
  assign rdata       = load_hit ? cur_word : 32'd0;
  assign mem_rd_req  = (state_reg == RD_REQ);
  assign mem_rd_addr = {fill_line_reg, {LINE_LSB{1'b0}}};
  assign mem_wr_req  = (state_reg == WR_REQ);
  assign mem_wr_addr = {req_addr[31:2], 2'b00};
  assign mem_wr_data = req_wdata;
  assign mem_wr_strb = req_wstrb;

  // Line storage; only the valid bits need clearing on reset.
  always_ff @(posedge clk) begin
    if ((state_reg == RD_DATA) && mem_rd_valid) begin
      data_mem[fill_idx][cnt_reg] <= mem_rd_data;
      tag_mem[fill_idx]           <= fill_tag;
    end
    if (store_done && hit) begin
      data_mem[req_idx][req_off] <= merged_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      valid_reg     <= '0;
      fill_line_reg <= '0;
      refilled_reg  <= 1'b0;
`ifdef DCACHE_PERF_CNT_EN
      hit_cnt       <= 32'd0;
      miss_cnt      <= 32'd0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          refilled_reg <= 1'b0;
`ifdef DCACHE_PERF_CNT_EN
          if (load_hit && !refilled_reg) hit_cnt <= hit_cnt + 32'd1;
`endif
          if (req_valid) begin
            if (req_we) begin
              state_reg <= WR_REQ;
            end else if (!hit) begin
              // Latch the line so the refill survives the request being withdrawn.
              state_reg     <= RD_REQ;
              fill_line_reg <= req_addr[31:LINE_LSB];
`ifdef DCACHE_PERF_CNT_EN
              miss_cnt      <= miss_cnt + 32'd1;
`endif
            end
          end
        end
        RD_REQ: begin
          if (mem_rd_rdy) begin
            state_reg <= RD_DATA;
            cnt_reg   <= '0;
          end
        end
        RD_DATA: begin
          if (mem_rd_valid) cnt_reg <= cnt_reg + 1'b1;
          if (last_beat) begin
            valid_reg[fill_idx] <= 1'b1;
            refilled_reg        <= 1'b1;
            state_reg           <= IDLE;
          end
        end
        WR_REQ: begin
          if (mem_wr_rdy) state_reg <= WR_RESP;
        end
        WR_RESP: begin
          if (mem_wr_done) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
